branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): XLEN, 32, PC width; DRAIN_CYCLES, 1, post-accept cycles discarding stale fetch data (legal 1..3).
REQ-002 Ports SHALL be (name, direction, width, meaning); clock and reset are decided as: clk, in, 1, single clock; reset_n, in, 1, asynchronous active-low reset.
REQ-003 exe_valid_i  in  1  valid instruction in EXE this cycle.
REQ-004 branch_v_i  in  1  branch unit taken/jump indication.
REQ-005 pc_nxt_i  in  XLEN  branch unit target.
REQ-006 trap_v_i  in  1  CSR trap/mret redirect request.
REQ-007 trap_pc_i  in  XLEN  trap target.
REQ-008 if_ready_i  in  1  fetch accepts redirect.
REQ-009 redirect_v_o  out  1  redirect request to fetch.
REQ-010 redirect_pc_o  out  XLEN  redirect target.
REQ-011 flush_if_o, flush_dec_o  out  1 each  kill IF / DEC stage contents.
REQ-012 exe_stall_o  out  1  hold EXE while a redirect is outstanding.
REQ-013 misalign_v_o  out  1  one-cycle instruction-address-misaligned pulse.
REQ-014 misalign_addr_o  out  XLEN  offending target.
REQ-015 taken_cnt_o  out  32  count of accepted branch redirects.

Function
REQ-016 FSM states SHALL be IDLE, REQ and DRAIN.
REQ-017 Event in IDLE SHALL be trap_v_i, or exe_valid_i & branch_v_i; trap SHALL win when both are present (branch dropped, not counted).
REQ-018 Branch target with pc_nxt_i[1:0] != 0 SHALL NOT redirect: misalign_v_o=1 next cycle, misalign_addr_o=pc_nxt_i, FSM stays IDLE.
REQ-019 A legal event SHALL register the target into redirect_pc_o and enter REQ next cycle; redirect_v_o = (state==REQ).
REQ-020 In REQ, flush_if_o=flush_dec_o=1 every cycle and exe_stall_o=1.
REQ-021 In REQ with if_ready_i=1, the handshake SHALL complete that cycle and the FSM SHALL enter DRAIN with counter = DRAIN_CYCLES-1.
REQ-022 In REQ, redirect_pc_o SHALL remain stable until acceptance, except that trap_v_i in REQ SHALL overwrite redirect_pc_o with trap_pc_i and remain in REQ.
REQ-023 In DRAIN, flush_if_o=1, flush_dec_o=0, exe_stall_o=0; at counter 0 the FSM SHALL return to IDLE, otherwise decrement.
REQ-024 New events in DRAIN SHALL be handled as in IDLE (re-enter REQ, counter abandoned).
REQ-025 Branch events in REQ SHALL be ignored (EXE is stalled).
REQ-026 taken_cnt_o SHALL increment by 1 on each accepted handshake whose source is a branch and SHALL wrap 0xFFFFFFFF -> 0.
REQ-027 Outputs SHALL be registered; redirect_v_o and the flush outputs SHALL derive only from state.

Reset
REQ-028 On reset_n=0, asynchronously: state=IDLE, redirect_v_o=0, redirect_pc_o=0, flush_if_o=0, flush_dec_o=0, exe_stall_o=0, misalign_v_o=0, misalign_addr_o=0, taken_cnt_o=0.
REQ-029 Reset asserted in REQ or DRAIN SHALL abandon the request with no counter update; the first event after release SHALL behave as from IDLE.

Verification
REQ-030 Branch, exe_valid=1, pc_nxt=0x0000_1000, if_ready=1 on first REQ cycle -> redirect_v_o 1 cycle with pc 0x1000, flush_if_o 1+DRAIN_CYCLES cycles, taken_cnt_o=1.
REQ-031 Same branch with if_ready low 3 cycles -> redirect_v_o, exe_stall_o and the flush outputs held 4 cycles, pc stable at 0x1000.
REQ-032 Simultaneous branch (0x2000) and trap (0x8000_0000) -> redirect_pc_o=0x8000_0000, taken_cnt_o unchanged.
REQ-033 Branch to 0x0000_1002 -> misalign_v_o single pulse, misalign_addr_o=0x1002, no redirect_v_o, no flush.
REQ-034 reset_n low mid-REQ then released -> all outputs 0 immediately, IDLE, counter unchanged at 0.
REQ-035 taken_cnt_o forced to 0xFFFFFFFF then one accepted branch -> taken_cnt_o=0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch/trap redirect controller: arbitrates branch and trap redirects, handshakes the
// target to fetch, flushes the front-end, and counts accepted branch redirects.
module branch_redirect_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            exe_valid_i,
   input  logic            branch_v_i,
   input  logic [XLEN-1:0] pc_nxt_i,
   input  logic            trap_v_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            if_ready_i,
   output logic            redirect_v_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            flush_if_o,
   output logic            flush_dec_o,
   output logic            exe_stall_o,
   output logic            misalign_v_o,
   output logic [XLEN-1:0] misalign_addr_o,
   output logic [31:0]     taken_cnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              src_br_q, src_br_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       taken_q, taken_d;
   logic              mis_v_q, mis_v_d;
   logic [XLEN-1:0]   mis_addr_q, mis_addr_d;
   logic              redirect_v_q, flush_if_q, flush_dec_q, exe_stall_q;
   logic              branch_ev;

   assign branch_ev = exe_valid_i & branch_v_i;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      src_br_d   = src_br_q;
      cnt_d      = cnt_q;
      taken_d    = taken_q;
      mis_v_d    = 1'b0;
      mis_addr_d = mis_addr_q;
      case (state_q)
         IDLE, DRAIN: begin
            if (state_q == DRAIN) begin
               if (cnt_q == 2'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 2'd1;
            end
            // Trap wins over a simultaneous branch; the branch is dropped uncounted.
            if (trap_v_i) begin
               state_d  = REQ;
               pc_d     = trap_pc_i;
               src_br_d = 1'b0;
            end else if (branch_ev) begin
               if (pc_nxt_i[1:0] != 2'b00) begin
                  mis_v_d    = 1'b1;
                  mis_addr_d = pc_nxt_i;
               end else begin
                  state_d  = REQ;
                  pc_d     = pc_nxt_i;
                  src_br_d = 1'b1;
               end
            end
         end
         REQ: begin
            // A late trap retargets the pending request instead of completing it.
            if (trap_v_i) begin
               pc_d     = trap_pc_i;
               src_br_d = 1'b0;
            end else if (if_ready_i) begin
               state_d = DRAIN;
               cnt_d   = 2'(DRAIN_CYCLES - 1);
               if (src_br_q) taken_d = taken_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         src_br_q     <= 1'b0;
         cnt_q        <= '0;
         taken_q      <= '0;
         mis_v_q      <= 1'b0;
         mis_addr_q   <= '0;
         redirect_v_q <= 1'b0;
         flush_if_q   <= 1'b0;
         flush_dec_q  <= 1'b0;
         exe_stall_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         src_br_q     <= src_br_d;
         cnt_q        <= cnt_d;
         taken_q      <= taken_d;
         mis_v_q      <= mis_v_d;
         mis_addr_q   <= mis_addr_d;
         redirect_v_q <= (state_d == REQ);
         flush_if_q   <= (state_d == REQ) || (state_d == DRAIN);
         flush_dec_q  <= (state_d == REQ);
         exe_stall_q  <= (state_d == REQ);
      end
   end

   assign redirect_v_o    = redirect_v_q;
   assign redirect_pc_o   = pc_q;
   assign flush_if_o      = flush_if_q;
   assign flush_dec_o     = flush_dec_q;
   assign exe_stall_o     = exe_stall_q;
   assign misalign_v_o    = mis_v_q;
   assign misalign_addr_o = mis_addr_q;
   assign taken_cnt_o     = taken_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

   localparam int unsigned XLEN = 32;
   localparam int unsigned DC   = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            exe_valid_i, branch_v_i, trap_v_i, if_ready_i;
   logic [XLEN-1:0] pc_nxt_i, trap_pc_i;
   logic            redirect_v_o, flush_if_o, flush_dec_o, exe_stall_o, misalign_v_o;
   logic [XLEN-1:0] redirect_pc_o, misalign_addr_o;
   logic [31:0]     taken_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   branch_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DC)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .exe_valid_i     (exe_valid_i),
      .branch_v_i      (branch_v_i),
      .pc_nxt_i        (pc_nxt_i),
      .trap_v_i        (trap_v_i),
      .trap_pc_i       (trap_pc_i),
      .if_ready_i      (if_ready_i),
      .redirect_v_o    (redirect_v_o),
      .redirect_pc_o   (redirect_pc_o),
      .flush_if_o      (flush_if_o),
      .flush_dec_o     (flush_dec_o),
      .exe_stall_o     (exe_stall_o),
      .misalign_v_o    (misalign_v_o),
      .misalign_addr_o (misalign_addr_o),
      .taken_cnt_o     (taken_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input string tag, input logic v, input logic fi, input logic fd,
                      input logic st);
      chk({tag, ".redirect_v"}, {31'd0, redirect_v_o}, {31'd0, v});
      chk({tag, ".flush_if"},   {31'd0, flush_if_o},   {31'd0, fi});
      chk({tag, ".flush_dec"},  {31'd0, flush_dec_o},  {31'd0, fd});
      chk({tag, ".exe_stall"},  {31'd0, exe_stall_o},  {31'd0, st});
   endtask

   task automatic branch(input logic [31:0] pc);
      exe_valid_i = 1'b1; branch_v_i = 1'b1; pc_nxt_i = pc;
   endtask

   task automatic idle_in();
      exe_valid_i = 1'b0; branch_v_i = 1'b0; trap_v_i = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; idle_in(); if_ready_i = 1'b0;
      pc_nxt_i = '0; trap_pc_i = '0;
      #1;
      ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.pc", redirect_pc_o, 32'h0);
      chk("rst.taken", taken_cnt_o, 32'h0);
      chk("rst.mis_v", {31'd0, misalign_v_o}, 32'h0);
      chk("rst.mis_addr", misalign_addr_o, 32'h0);
      step(); step();
      reset_n = 1'b1;
      step();

      // reset in the middle of a pending request
      branch(32'h5000);
      step();
      idle_in();
      ctl("mid_req", 1'b1, 1'b1, 1'b1, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      ctl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("async_rst.pc", redirect_pc_o, 32'h0);
      chk("async_rst.taken", taken_cnt_o, 32'h0);
      @(negedge clk) reset_n = 1'b1;
      step();
      ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst.taken", taken_cnt_o, 32'h0);

      // immediate acceptance
      if_ready_i = 1'b1;
      branch(32'h1000);
      step();
      idle_in();
      ctl("acc.req", 1'b1, 1'b1, 1'b1, 1'b1);
      chk("acc.pc", redirect_pc_o, 32'h1000);
      for (int i = 0; i < DC; i++) begin
         step();
         ctl("acc.drain", 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("acc.taken", taken_cnt_o, 32'd1);
      step();
      ctl("acc.idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // fetch back-pressure for three cycles; a branch during REQ is ignored
      if_ready_i = 1'b0;
      branch(32'h1000);
      step();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         ctl("bp.req", 1'b1, 1'b1, 1'b1, 1'b1);
         chk("bp.pc", redirect_pc_o, 32'h1000);
         if (i == 0) branch(32'h9000);
         else if (i == 1) idle_in();
         if (i < 3) step();
      end
      if_ready_i = 1'b1;
      step();
      ctl("bp.drain", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bp.taken", taken_cnt_o, 32'd2);
      step(); step();

      // simultaneous branch and trap
      branch(32'h2000);
      trap_v_i = 1'b1; trap_pc_i = 32'h8000_0000;
      step();
      idle_in();
      ctl("both.req", 1'b1, 1'b1, 1'b1, 1'b1);
      chk("both.pc", redirect_pc_o, 32'h8000_0000);
      step();
      chk("both.taken", taken_cnt_o, 32'd2);
      step(); step();

      // trap arriving while a branch redirect waits
      if_ready_i = 1'b0;
      branch(32'h3000);
      step();
      idle_in();
      chk("retgt.pc0", redirect_pc_o, 32'h3000);
      trap_v_i = 1'b1; trap_pc_i = 32'h4000;
      step();
      trap_v_i = 1'b0;
      ctl("retgt.req", 1'b1, 1'b1, 1'b1, 1'b1);
      chk("retgt.pc1", redirect_pc_o, 32'h4000);
      if_ready_i = 1'b1;
      step();
      chk("retgt.v", {31'd0, redirect_v_o}, 32'h0);
      chk("retgt.taken", taken_cnt_o, 32'd2);
      step(); step();

      // misaligned branch target
      branch(32'h1002);
      step();
      idle_in();
      chk("mis.v", {31'd0, misalign_v_o}, 32'h1);
      chk("mis.addr", misalign_addr_o, 32'h1002);
      ctl("mis", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("mis.pulse_end", {31'd0, misalign_v_o}, 32'h0);
      ctl("mis.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // new branch during DRAIN re-enters REQ
      branch(32'h6000);
      step();
      idle_in();
      step();
      ctl("dr.drain", 1'b0, 1'b1, 1'b0, 1'b0);
      branch(32'h7000);
      step();
      idle_in();
      ctl("dr.rereq", 1'b1, 1'b1, 1'b1, 1'b1);
      chk("dr.pc", redirect_pc_o, 32'h7000);
      step();
      chk("dr.taken", taken_cnt_o, 32'd4);
      step(); step();

      // counter wrap
      force dut.taken_q = 32'hFFFF_FFFF;
      #1;
      release dut.taken_q;
      chk("wrap.pre", taken_cnt_o, 32'hFFFF_FFFF);
      branch(32'h0000_0100);
      step();
      idle_in();
      step();
      chk("wrap.post", taken_cnt_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
